// File: rtl/alu_iterative.sv
// Purpose: sequential ALU for the execute stage. It does add/sub, logic ops, compares and
//          shifts in one step, and an unsigned multiply/divide that produces one bit per cycle.
// Latency: simple ops give outValid in cycle N+1. MUL/MULHU/DIVU/REMU give it in cycle N+WIDTH+1.
//          N is the accept cycle.
// Backpressure: one request is in flight at a time. inReady is high only in IDLE.
//          The result is held until outReady is seen together with outValid.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   flush               synchronous abort; returns to IDLE and keeps the last result
//   inValid / inReady   request handshake (inputA, inputB, aluControl)
//   outValid / outReady response handshake (aluResult, zero, illegalOp)
//   busy                high while an iterative op is running
module alu_iterative #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    input  logic [3:0]       aluControl,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] aluResult,
    output logic             zero,
    output logic             illegalOp,
    output logic             busy
);

    // The counter must hold the value WIDTH itself, so it is one bit wider than a shift amount.
    localparam int               CNT_W    = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op_q;       // latched opcode; selects the final iterative result
    logic [WIDTH-1:0]   opb_q;      // multiplicand for MUL/MULHU, divisor for DIVU/REMU
    logic [2*WIDTH-1:0] acc_q;      // product accumulator; the multiplier starts in the low half
    logic [WIDTH:0]     rem_q;      // partial remainder for the restoring divide
    logic [WIDTH-1:0]   quo_q;      // dividend shifts out the top while quotient bits shift in

    // ------------------------------------------------------------------
    // Simple ops. These are computed straight from the ports in the accept cycle.
    // ------------------------------------------------------------------
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   simple_res;
    logic               is_iter;
    logic               is_illegal;

    assign shamt      = inputB[SHAMT_W-1:0];
    assign is_iter    = (aluControl == OP_MUL)  || (aluControl == OP_MULHU) ||
                        (aluControl == OP_DIVU) || (aluControl == OP_REMU);
    assign is_illegal = (aluControl[3:1] == 3'b111);

    always_comb begin
        simple_res = '0;
        case (aluControl)
            OP_ADD:  simple_res = inputA + inputB;
            OP_SUB:  simple_res = inputA - inputB;
            OP_AND:  simple_res = inputA & inputB;
            OP_OR:   simple_res = inputA | inputB;
            OP_XOR:  simple_res = inputA ^ inputB;
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(inputA) < $signed(inputB))};
            OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (inputA < inputB)};
            OP_SLL:  simple_res = inputA << shamt;
            OP_SRL:  simple_res = inputA >> shamt;
            OP_SRA:  simple_res = $signed(inputA) >>> shamt;
            default: simple_res = '0;   // Iterative ops finish later; 1110/1111 return zero.
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration step for the multiplier and the divider.
    // Both step every BUSY cycle. Only the result chosen by op_q is used.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH:0]     rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [WIDTH-1:0]   iter_res;

    always_comb begin
        // Shift-add multiply. Add the multiplicand to the upper half when the current
        // multiplier bit is set. Then shift the whole accumulator right by one,
        // keeping the carry-out.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide. Shift the next dividend bit into the remainder, then do a
        // trial subtract. div_shift is never larger than 2^(WIDTH+1), so bit WIDTH+1 of
        // the difference acts as the borrow.
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_diff  = div_shift - {2'b00, opb_q};
        if (!div_diff[WIDTH+1]) begin
            rem_nxt = div_diff[WIDTH:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = div_shift[WIDTH:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
        end
        // With a zero divisor every trial subtract succeeds. The quotient then becomes all
        // ones and the remainder ends up as the dividend. No special case is needed.

        case (op_q)
            OP_MUL:   iter_res = acc_nxt[WIDTH-1:0];
            OP_MULHU: iter_res = acc_nxt[2*WIDTH-1:WIDTH];
            OP_DIVU:  iter_res = quo_nxt;
            default:  iter_res = rem_nxt[WIDTH-1:0];
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM. All outputs are registered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            inReady   <= 1'b1;
            outValid  <= 1'b0;
            busy      <= 1'b0;
            aluResult <= '0;
            zero      <= 1'b0;
            illegalOp <= 1'b0;
            cnt       <= '0;
            op_q      <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
        end else if (flush) begin
            // Abort whatever is in flight. The last result stays visible on the outputs.
            // Clearing inReady's path through IDLE also drops a request made in this cycle.
            state    <= S_IDLE;
            inReady  <= 1'b1;
            outValid <= 1'b0;
            busy     <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (inValid && inReady) begin
                        op_q    <= aluControl;
                        opb_q   <= inputB;
                        acc_q   <= {{WIDTH{1'b0}}, inputA};
                        rem_q   <= '0;
                        quo_q   <= inputA;
                        inReady <= 1'b0;
                        if (is_iter) begin
                            state <= S_BUSY;
                            busy  <= 1'b1;
                            cnt   <= CNT_LOAD;
                        end else begin
                            state     <= S_DONE;
                            outValid  <= 1'b1;
                            aluResult <= simple_res;
                            zero      <= (simple_res == '0);
                            illegalOp <= is_illegal;
                        end
                    end
                end

                S_BUSY: begin
                    acc_q <= acc_nxt;
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt   <= cnt - CNT_ONE;
                    // This is the last of the WIDTH iterations. Take the result from the
                    // next-state value so no extra cycle is spent.
                    if (cnt == CNT_ONE) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        outValid  <= 1'b1;
                        aluResult <= iter_res;
                        zero      <= (iter_res == '0);
                        illegalOp <= 1'b0;
                    end
                end

                S_DONE: begin
                    if (outReady) begin
                        state    <= S_IDLE;
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    inReady  <= 1'b1;
                    outValid <= 1'b0;
                    busy     <= 1'b0;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iterative.sv
// Purpose: self-checking bench for alu_iterative with WIDTH=32. It uses directed vectors
//          with hand-computed results.
// Latency: checks outValid timing (N+1 for simple ops, N+33 for iterative ops) and BUSY duration.
// Backpressure: holds outReady low after completion and checks that the result stays put.
module tb_alu_iterative;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [31:0] inputA;
    logic [31:0] inputB;
    logic [3:0]  aluControl;
    logic        outValid;
    logic        outReady;
    logic [31:0] aluResult;
    logic        zero;
    logic        illegalOp;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_iterative #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .inValid    (inValid),
        .inReady    (inReady),
        .inputA     (inputA),
        .inputB     (inputB),
        .aluControl (aluControl),
        .outValid   (outValid),
        .outReady   (outReady),
        .aluResult  (aluResult),
        .zero       (zero),
        .illegalOp  (illegalOp),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Send one request from IDLE, measure latency, check the result, optionally stall the
    // response for 'hold' cycles, then complete the handshake.
    // The task is entered and left at posedge+1.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic exp_ill,
                          input int hold);
        int lat;
        int busy_cnt;
        int exp_lat;
        exp_lat = (op inside {4'hA, 4'hB, 4'hC, 4'hD}) ? 33 : 1;
        check_eq({tag, "_inready"}, inReady, 1);
        inValid = 1'b1; aluControl = op; inputA = a; inputB = b;
        @(posedge clk); #1;
        // Scramble the operands so that the DUT has to use its own copies.
        inValid = 1'b0; aluControl = 4'($urandom); inputA = $urandom; inputB = $urandom;
        lat = 1;
        busy_cnt = 0;
        while (!outValid && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_busycycles"}, busy_cnt, exp_lat - 1);
        check_eq({tag, "_result"}, aluResult, exp);
        check_eq({tag, "_zero"}, zero, (exp == 32'h0));
        check_eq({tag, "_illegal"}, illegalOp, exp_ill);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq({tag, "_hold_result"}, aluResult, exp);
            check_eq({tag, "_hold_outvalid"}, outValid, 1);
            check_eq({tag, "_hold_inready"}, inReady, 0);
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        check_eq({tag, "_outvalid_clr"}, outValid, 0);
        check_eq({tag, "_inready_back"}, inReady, 1);
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ill;
        logic [3:0]  hold;
    } vec_t;

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{op: 4'h0, a: 32'hFFFFFFFF, b: 32'h00000001, exp: 32'h00000000, ill: 1'b0, hold: 4'd0}; // ADD wrap
        vecs[1]  = '{op: 4'h1, a: 32'h00000003, b: 32'h00000005, exp: 32'hFFFFFFFE, ill: 1'b0, hold: 4'd0}; // SUB
        vecs[2]  = '{op: 4'h2, a: 32'hF0F0F0F0, b: 32'hFF00FF00, exp: 32'hF000F000, ill: 1'b0, hold: 4'd0}; // AND
        vecs[3]  = '{op: 4'h3, a: 32'hF0F0F0F0, b: 32'hFF00FF00, exp: 32'hFFF0FFF0, ill: 1'b0, hold: 4'd0}; // OR
        vecs[4]  = '{op: 4'h4, a: 32'hF0F0F0F0, b: 32'hFF00FF00, exp: 32'h0FF00FF0, ill: 1'b0, hold: 4'd0}; // XOR
        vecs[5]  = '{op: 4'h5, a: 32'hFFFFFFFF, b: 32'h00000001, exp: 32'h00000001, ill: 1'b0, hold: 4'd0}; // SLT
        vecs[6]  = '{op: 4'h6, a: 32'hFFFFFFFF, b: 32'h00000001, exp: 32'h00000000, ill: 1'b0, hold: 4'd0}; // SLTU
        vecs[7]  = '{op: 4'h7, a: 32'h00000001, b: 32'h0000001F, exp: 32'h80000000, ill: 1'b0, hold: 4'd0}; // SLL
        vecs[8]  = '{op: 4'h8, a: 32'h80000000, b: 32'h00000021, exp: 32'h40000000, ill: 1'b0, hold: 4'd0}; // SRL, amt 1
        vecs[9]  = '{op: 4'h9, a: 32'h80000000, b: 32'h00000024, exp: 32'hF8000000, ill: 1'b0, hold: 4'd0}; // SRA, amt 4
        vecs[10] = '{op: 4'hA, a: 32'h00010000, b: 32'h00010000, exp: 32'h00000000, ill: 1'b0, hold: 4'd0}; // MUL
        vecs[11] = '{op: 4'hB, a: 32'h00010000, b: 32'h00010000, exp: 32'h00000001, ill: 1'b0, hold: 4'd0}; // MULHU
        vecs[12] = '{op: 4'hA, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, exp: 32'h00000001, ill: 1'b0, hold: 4'd0}; // MUL
        vecs[13] = '{op: 4'hB, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, exp: 32'hFFFFFFFE, ill: 1'b0, hold: 4'd0}; // MULHU
        vecs[14] = '{op: 4'hC, a: 32'd100,      b: 32'd7,        exp: 32'd14,       ill: 1'b0, hold: 4'd5}; // DIVU + stall
        vecs[15] = '{op: 4'hD, a: 32'd100,      b: 32'd7,        exp: 32'd2,        ill: 1'b0, hold: 4'd0}; // REMU
        vecs[16] = '{op: 4'hD, a: 32'd5,        b: 32'd0,        exp: 32'd5,        ill: 1'b0, hold: 4'd0}; // REMU /0
        vecs[17] = '{op: 4'hC, a: 32'd5,        b: 32'd0,        exp: 32'hFFFFFFFF, ill: 1'b0, hold: 4'd0}; // DIVU /0
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ov_seen;
        reset = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        inputA = '0; inputB = '0; aluControl = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_inready", inReady, 1);
        check_eq("rst_outvalid", outValid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_result", aluResult, 0);
        check_eq("rst_zero", zero, 0);
        check_eq("rst_illegal", illegalOp, 0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++)
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                   vecs[i].ill, int'(vecs[i].hold));

        // Flush in cycle N+10 of a MUL. The result of the DIVU 5/0 before it must survive.
        inValid = 1'b1; aluControl = 4'hA; inputA = 32'h1234; inputB = 32'h5678;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_eq("flush_busy_before", busy, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_busy_after", busy, 0);
        check_eq("flush_inready", inReady, 1);
        check_eq("flush_outvalid", outValid, 0);
        check_eq("flush_result_kept", aluResult, 32'hFFFFFFFF);
        ov_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (outValid) ov_seen++;
        end
        check_eq("flush_outvalid_never", ov_seen, 0);

        // A request made in the same cycle as flush must be dropped.
        inValid = 1'b1; flush = 1'b1; aluControl = 4'h0; inputA = 32'd1; inputB = 32'd1;
        @(posedge clk); #1;
        inValid = 1'b0; flush = 1'b0;
        check_eq("flushreq_outvalid", outValid, 0);
        check_eq("flushreq_inready", inReady, 1);
        @(posedge clk); #1;
        check_eq("flushreq_outvalid_later", outValid, 0);

        // Illegal opcodes.
        run_op("ill_e", 4'hE, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b1, 0);
        run_op("ill_f", 4'hF, 32'hDEADBEEF, 32'h00000001, 32'h0, 1'b1, 2);

        // Asynchronous reset in the middle of BUSY.
        inValid = 1'b1; aluControl = 4'hB; inputA = 32'hFFFF0000; inputB = 32'h00FF00FF;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("arst_busy_before", busy, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_inready", inReady, 1);
        check_eq("arst_outvalid", outValid, 0);
        check_eq("arst_result", aluResult, 0);
        check_eq("arst_zero", zero, 0);
        check_eq("arst_illegal", illegalOp, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op("post_rst_add", 4'h0, 32'd2, 32'd3, 32'd5, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
